writeback_regfile: RTL and testbench

- Write-back end of the Y86-64 pipeline.
- Holds the W pipeline register, which it loads from the memory stage.
- Commits W_valE and W_valM into the 15-entry 64-bit program register file, and drives rax..r14 to the decode stage.
- Publishes the W_* forwarding fields, tracks sticky processor status and counts retired instructions.

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/y86_regfile.sv | 45 ++++
 rtl/writeback_regfile.sv | 131 +++++++++++++
 tb/tb_writeback_regfile.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the write-back pipeline register layout, used by decode and
// write-back.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  localparam int unsigned NUM_REGS = 15;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: REG_NONE,
    dst_m: REG_NONE
  };

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit program register file with E and M write ports; M wins when both target one
// register. All registers are exposed flat, index 0 in the low 64 bits.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we_e,
  input  logic [3:0]               i_dst_e,
  input  logic [63:0]              i_val_e,
  input  logic                     i_we_m,
  input  logic [3:0]               i_dst_m,
  input  logic [63:0]              i_val_m,
  output logic [NUM_REGS*64-1:0]   o_regs
);

  logic [63:0] r_regs [NUM_REGS];

  // Index F never matches any slot, so "no destination" needs no extra gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (4'(i) == RSP) ? RSP_INIT : 64'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_we_m && (i_dst_m == 4'(i))) begin
          r_regs[i] <= i_val_m;
        end else if (i_we_e && (i_dst_e == 4'(i))) begin
          r_regs[i] <= i_val_e;
        end
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_regs[i*64 +: 64] = r_regs[i];
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, register commit, sticky processor status
// and retired-instruction counter.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [1:0]       M_stat,
  input  logic [3:0]       M_icode,
  input  logic [63:0]      M_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  output logic [1:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [63:0]      rax,
  output logic [63:0]      rcx,
  output logic [63:0]      rdx,
  output logic [63:0]      rbx,
  output logic [63:0]      rsp,
  output logic [63:0]      rbp,
  output logic [63:0]      rsi,
  output logic [63:0]      rdi,
  output logic [63:0]      r8,
  output logic [63:0]      r9,
  output logic [63:0]      r10,
  output logic [63:0]      r11,
  output logic [63:0]      r12,
  output logic [63:0]      r13,
  output logic [63:0]      r14,
  output logic [1:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  w_reg_t           r_w;
  w_reg_t           w_m_in;
  logic [1:0]       r_proc_stat;
  logic             r_halted;
  logic [CNT_W-1:0] r_instret;
  logic             w_commit;
  logic             w_retire;
  logic [NUM_REGS*64-1:0] w_regs;

  assign w_m_in = '{
    stat:  M_stat,
    icode: M_icode,
    val_e: M_valE,
    val_m: m_valM,
    dst_e: M_dstE,
    dst_m: M_dstM
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w <= W_BUBBLE;
    end else if (!W_stall) begin
      r_w <= W_bubble ? W_BUBBLE : w_m_in;
    end
  end

  // Commit and retirement look at the W contents present before this edge's update.
  assign w_commit = (r_proc_stat == STAT_AOK) && (r_w.stat == STAT_AOK);
  assign w_retire = w_commit && (r_w.icode != I_NOP) && !W_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_proc_stat <= STAT_AOK;
      r_halted    <= 1'b0;
      r_instret   <= '0;
    end else begin
      if ((r_proc_stat == STAT_AOK) && (r_w.stat != STAT_AOK)) begin
        r_proc_stat <= r_w.stat;
        r_halted    <= 1'b1;
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  y86_regfile #(
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we_e  (w_commit && (r_w.dst_e != REG_NONE)),
    .i_dst_e (r_w.dst_e),
    .i_val_e (r_w.val_e),
    .i_we_m  (w_commit && (r_w.dst_m != REG_NONE)),
    .i_dst_m (r_w.dst_m),
    .i_val_m (r_w.val_m),
    .o_regs  (w_regs)
  );

  assign W_stat    = r_w.stat;
  assign W_icode   = r_w.icode;
  assign W_valE    = r_w.val_e;
  assign W_valM    = r_w.val_m;
  assign W_dstE    = r_w.dst_e;
  assign W_dstM    = r_w.dst_m;
  assign proc_stat = r_proc_stat;
  assign halted    = r_halted;
  assign instret   = r_instret;

  assign rax = w_regs[0*64  +: 64];
  assign rcx = w_regs[1*64  +: 64];
  assign rdx = w_regs[2*64  +: 64];
  assign rbx = w_regs[3*64  +: 64];
  assign rsp = w_regs[4*64  +: 64];
  assign rbp = w_regs[5*64  +: 64];
  assign rsi = w_regs[6*64  +: 64];
  assign rdi = w_regs[7*64  +: 64];
  assign r8  = w_regs[8*64  +: 64];
  assign r9  = w_regs[9*64  +: 64];
  assign r10 = w_regs[10*64 +: 64];
  assign r11 = w_regs[11*64 +: 64];
  assign r12 = w_regs[12*64 +: 64];
  assign r13 = w_regs[13*64 +: 64];
  assign r14 = w_regs[14*64 +: 64];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, commit, popq priority, stall, sticky halt and
// asynchronous mid-stream reset.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_stall, W_bubble;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE, m_valM;
  logic [3:0]  M_dstE, M_dstM;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;
  logic [1:0]  proc_stat;
  logic        halted;
  logic [31:0] instret;
  logic [63:0] regs [15];

  int errors = 0;
  int checks = 0;

  writeback_regfile #(
    .RSP_INIT (64'h100),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .W_stall   (W_stall),
    .W_bubble  (W_bubble),
    .M_stat    (M_stat),
    .M_icode   (M_icode),
    .M_valE    (M_valE),
    .m_valM    (m_valM),
    .M_dstE    (M_dstE),
    .M_dstM    (M_dstM),
    .W_stat    (W_stat),
    .W_icode   (W_icode),
    .W_valE    (W_valE),
    .W_valM    (W_valM),
    .W_dstE    (W_dstE),
    .W_dstM    (W_dstM),
    .rax       (rax),
    .rcx       (rcx),
    .rdx       (rdx),
    .rbx       (rbx),
    .rsp       (rsp),
    .rbp       (rbp),
    .rsi       (rsi),
    .rdi       (rdi),
    .r8        (r8),
    .r9        (r9),
    .r10       (r10),
    .r11       (r11),
    .r12       (r12),
    .r13       (r13),
    .r14       (r14),
    .proc_stat (proc_stat),
    .halted    (halted),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  always_comb begin
    regs[0]  = rax; regs[1]  = rcx; regs[2]  = rdx; regs[3]  = rbx;
    regs[4]  = rsp; regs[5]  = rbp; regs[6]  = rsi; regs[7]  = rdi;
    regs[8]  = r8;  regs[9]  = r9;  regs[10] = r10; regs[11] = r11;
    regs[12] = r12; regs[13] = r13; regs[14] = r14;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_icode = ic; M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
  endtask

  task automatic drive_idle();
    drive_m(2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic test_reset();
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      logic [63:0] exp_v;
      exp_v = (i == 4) ? 64'h100 : 64'd0;
      checks++;
      if (regs[i] !== exp_v) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, regs[i], exp_v);
      end
    end
    checks++;
    if ({W_dstE, W_dstM, W_icode, W_stat} !== {4'hF, 4'hF, 4'h1, 2'd0}) begin
      errors++;
      $display("FAIL reset_w: got dstE=%h dstM=%h icode=%h stat=%0d expected F F 1 0",
               W_dstE, W_dstM, W_icode, W_stat);
    end
    checks++;
    if ({instret, halted, proc_stat} !== {32'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_status: got instret=%0d halted=%b stat=%0d expected 0 0 0",
               instret, halted, proc_stat);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_write();
    drive_m(2'd0, 4'h3, 64'h55, 64'd0, 4'h2, 4'hF);
    tick();
    checks++;
    if (W_valE !== 64'h55 || W_dstE !== 4'h2) begin
      errors++;
      $display("FAIL basic_w_load: got valE=%h dstE=%h expected 55 2", W_valE, W_dstE);
    end
    checks++;
    if (rdx !== 64'd0) begin
      errors++;
      $display("FAIL basic_no_writethrough: got rdx=%h expected 0", rdx);
    end
    W_bubble = 1'b1;
    tick();
    checks++;
    if (rdx !== 64'h55) begin
      errors++;
      $display("FAIL basic_commit: got rdx=%h expected 55", rdx);
    end
    checks++;
    if (instret !== 32'd1 || W_icode !== 4'h1) begin
      errors++;
      $display("FAIL basic_instret: got instret=%0d icode=%h expected 1 1", instret, W_icode);
    end
    W_bubble = 1'b0;
    drive_idle();
  endtask

  task automatic test_popq_rsp();
    drive_m(2'd0, 4'hB, 64'h200, 64'h300, 4'h4, 4'h4);
    tick();
    W_bubble = 1'b1;
    tick();
    checks++;
    if (rsp !== 64'h300) begin
      errors++;
      $display("FAIL popq_rsp: got rsp=%h expected 300", rsp);
    end
    checks++;
    if (instret !== 32'd2) begin
      errors++;
      $display("FAIL popq_instret: got %0d expected 2", instret);
    end
    W_bubble = 1'b0;
    drive_idle();
  endtask

  task automatic test_stall();
    drive_m(2'd0, 4'h2, 64'h9, 64'd0, 4'h1, 4'hF);
    tick();
    W_stall = 1'b1;
    drive_m(2'd0, 4'h6, 64'h77, 64'd0, 4'h6, 4'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (W_dstE !== 4'h1 || W_valE !== 64'h9 || rcx !== 64'h9 || instret !== 32'd2) begin
        errors++;
        $display("FAIL stall_hold%0d: got dstE=%h valE=%h rcx=%h instret=%0d expected 1 9 9 2",
                 c, W_dstE, W_valE, rcx, instret);
      end
    end
    W_bubble = 1'b1;
    tick();
    checks++;
    if (W_icode !== 4'h2 || W_dstE !== 4'h1) begin
      errors++;
      $display("FAIL stall_over_bubble: got icode=%h dstE=%h expected 2 1", W_icode, W_dstE);
    end
    W_stall = 1'b0;
    tick();
    checks++;
    if (instret !== 32'd3 || W_icode !== 4'h1 || rsi !== 64'd0) begin
      errors++;
      $display("FAIL stall_release: got instret=%0d icode=%h rsi=%h expected 3 1 0",
               instret, W_icode, rsi);
    end
    W_bubble = 1'b0;
    drive_idle();
  endtask

  task automatic test_halt_sticky();
    drive_m(2'd3, 4'h6, 64'h7, 64'd0, 4'h3, 4'hF);
    tick();
    checks++;
    if (W_stat !== 2'd3 || proc_stat !== 2'd0) begin
      errors++;
      $display("FAIL halt_w_stat: got W_stat=%0d proc_stat=%0d expected 3 0", W_stat, proc_stat);
    end
    drive_m(2'd0, 4'h3, 64'h11, 64'd0, 4'h0, 4'hF);
    tick();
    checks++;
    if (rbx !== 64'd0 || proc_stat !== 2'd3 || halted !== 1'b1 || instret !== 32'd3) begin
      errors++;
      $display("FAIL halt_enter: got rbx=%h stat=%0d halted=%b instret=%0d expected 0 3 1 3",
               rbx, proc_stat, halted, instret);
    end
    drive_m(2'd2, 4'h5, 64'h22, 64'h33, 4'h0, 4'h7);
    tick();
    checks++;
    if (rax !== 64'd0 || instret !== 32'd3) begin
      errors++;
      $display("FAIL halt_no_write: got rax=%h instret=%0d expected 0 3", rax, instret);
    end
    drive_idle();
    tick();
    checks++;
    if (proc_stat !== 2'd3 || halted !== 1'b1 || rdi !== 64'd0) begin
      errors++;
      $display("FAIL halt_sticky: got stat=%0d halted=%b rdi=%h expected 3 1 0",
               proc_stat, halted, rdi);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_m(2'd0, 4'h3, 64'hAB, 64'd0, 4'h6, 4'hF);
    tick();
    W_bubble = 1'b1;
    tick();
    checks++;
    if (rsi !== 64'hAB || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: got rsi=%h halted=%b expected ab 0", rsi, halted);
    end
    W_bubble = 1'b0;
    drive_m(2'd0, 4'h3, 64'h5, 64'd0, 4'h0, 4'hF);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (rsi !== 64'd0 || rsp !== 64'h100 || instret !== 32'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got rsi=%h rsp=%h instret=%0d halted=%b expected 0 100 0 0",
               rsi, rsp, instret, halted);
    end
    checks++;
    if (W_icode !== 4'h1 || W_dstE !== 4'hF) begin
      errors++;
      $display("FAIL mid_bubble: got icode=%h dstE=%h expected 1 f", W_icode, W_dstE);
    end
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (rax !== 64'd0) begin
      errors++;
      $display("FAIL mid_cancel: got rax=%h expected 0", rax);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_popq_rsp();
    test_stall();
    test_halt_sticky();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
